// File: rtl/nibble_serial_adder.sv
// Wide add sequenced through an external 4-bit adder, one nibble per clock, LSB nibble first.
// Optional feature macro: SERIAL_SUB_EN (adds in_sub for A-B via inverted B and carry-in 1).
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
`ifdef SERIAL_SUB_EN
  input  logic                   in_sub,
`endif
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IW-1:0]             idx;
  logic [NIBBLES-1:0][3:0]   a_reg;
  logic [NIBBLES-1:0][3:0]   b_reg;
  logic [NIBBLES-1:0][3:0]   sum_reg;
  logic                      carry_reg;
  logic                      last_nibble;
  logic                      sub_reg;

  assign last_nibble = (idx == IW'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_nibble) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; adder operands only driven while running
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_a   = a_reg[idx];
        add_b   = sub_reg ? ~b_reg[idx] : b_reg[idx];
        add_cin = carry_reg;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef SERIAL_SUB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_reg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_reg <= in_sub;
    end
  end
`else
  assign sub_reg = 1'b0;
`endif

  // Operand capture, per-nibble sum capture and carry chaining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            idx   <= '0;
`ifdef SERIAL_SUB_EN
            carry_reg <= in_sub ? 1'b1 : in_cin;
`else
            carry_reg <= in_cin;
`endif
          end
        end
        RUN: begin
          sum_reg[idx] <= add_s;
          carry_reg    <= add_cout;
          if (!last_nibble) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = W'(sum_reg);
  assign out_cout = carry_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder attached.
module tb_nibble_serial_adder;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub_v;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // The external 4-bit ripple adder the block drives
  always_comb {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SERIAL_SUB_EN
    .in_sub(in_sub_v),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for out_valid; lat counts edges after accept
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic poke,
                        output logic [W-1:0] sum, output logic cout, output int lat,
                        output logic cin0, output logic cin_rest);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub_v = sub;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    lat = 0;
    cin0 = add_cin;
    cin_rest = 1'b0;
    while (!out_valid && lat < 20) begin
      if (poke && lat == 1) begin
        in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (!out_valid) cin_rest |= add_cin;
    end
    in_valid = 1'b0;
    sum  = out_sum;
    cout = out_cout;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] r_sum;
  logic         r_cout;
  int           r_lat;
  logic         r_cin0;
  logic         r_cinr;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_sub_v = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_cout",  32'(out_cout),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_add_a", 32'({add_a, add_b, add_cin}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 1'b0, r_sum, r_cout, r_lat, r_cin0, r_cinr);
      check($sformatf("v%0d_latency", i), 32'(r_lat), 32'(NIB));
      check($sformatf("v%0d_sum", i), 32'(r_sum), 32'(vecs[i].sum));
      check($sformatf("v%0d_cout", i), 32'(r_cout), 32'(vecs[i].cout));
      handshake($sformatf("v%0d", i));
    end

    // Carry-in only reaches the adder in the first RUN cycle
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, r_sum, r_cout, r_lat, r_cin0, r_cinr);
    check("cin_first_cycle", 32'(r_cin0), 32'd1);
    check("cin_later_cycles", 32'(r_cinr), 32'd0);
    check("cin_sum", 32'(r_sum), 32'h5556);
    check("done_add_zero", 32'({add_a, add_b, add_cin}), 32'd0);
    handshake("cin");

    // Backpressure: result held while out_ready stays low
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, r_sum, r_cout, r_lat, r_cin0, r_cinr);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_sum", k), 32'(out_sum), 32'h0000);
      check($sformatf("bp%0d_cout", k), 32'(out_cout), 32'd1);
      check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    handshake("bp");
    check("bp_idle_stays", 32'(out_valid), 32'd0);

    // in_valid pulsed during RUN must be ignored
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, r_sum, r_cout, r_lat, r_cin0, r_cinr);
    check("ign_latency", 32'(r_lat), 32'(NIB));
    check("ign_sum", 32'(r_sum), 32'h3333);
    check("ign_cout", 32'(r_cout), 32'd0);
    handshake("ign");

    // Reset in the second RUN cycle abandons the operation
    @(negedge clk);
    in_a = 16'h0FFF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_sum", 32'(out_sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0, r_sum, r_cout, r_lat, r_cin0, r_cinr);
    check("postrst_sum", 32'(r_sum), 32'h1000);
    check("postrst_cout", 32'(r_cout), 32'd0);
    handshake("postrst");

`ifdef SERIAL_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, r_sum, r_cout, r_lat, r_cin0, r_cinr);
    check("sub_borrow_sum", 32'(r_sum), 32'hFFFE);
    check("sub_borrow_cout", 32'(r_cout), 32'd0);
    handshake("sub1");
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, r_sum, r_cout, r_lat, r_cin0, r_cinr);
    check("sub_pos_sum", 32'(r_sum), 32'h0002);
    check("sub_pos_cout", 32'(r_cout), 32'd1);
    handshake("sub2");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
